digit_serial_adder: RTL and testbench

//   Parametrised, multi-cycle add/subtract unit built around the team's one-bit full-adder cell
//   (S = ci^a^b, cout = maj(a,b,ci)). Each cycle, DIGIT full-adder cells in a ripple chain process

---
 rtl/digit_serial_adder.sv | 87 ++++++++
 tb/tb_digit_serial_adder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_serial_adder.sv
// digit_serial_adder: digit-serial add/subtract with a registered carry between digits and valid/ready handshakes
module digit_serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);
  if (DIGIT < 1 || DIGIT > WIDTH || WIDTH % DIGIT != 0) begin : g_bad_param
    $error("digit_serial_adder: DIGIT must divide WIDTH and lie in 1..WIDTH");
  end
  localparam int N = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] a_r, b_r, acc, acc_nx;
  logic carry;
  logic [CW-1:0] cnt;
  logic [DIGIT-1:0] da, db, ds;
  logic [DIGIT:0] c;
  logic last;
  function automatic logic [1:0] full_adder(input logic x, input logic y, input logic cin);
    return {(x & y) | (x & cin) | (y & cin), x ^ y ^ cin};
  endfunction
  assign da = a_r[int'(cnt)*DIGIT +: DIGIT];
  assign db = b_r[int'(cnt)*DIGIT +: DIGIT];
  assign last = cnt == CW'(N - 1);
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  always_comb begin
    c = '0;
    ds = '0;
    c[0] = carry;
    for (int i = 0; i < DIGIT; i++) {c[i+1], ds[i]} = full_adder(da[i], db[i], c[i]);
    acc_nx = acc;
    acc_nx[int'(cnt)*DIGIT +: DIGIT] = ds;
  end
  always_comb begin
    state_nx = (state == IDLE) ? (in_valid ? RUN : IDLE) :
               (state == RUN)  ? (last ? DONE : RUN) :
               (state == DONE && !out_ready) ? DONE : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_r <= '0;
      b_r <= '0;
      acc <= '0;
      carry <= 1'b0;
      cnt <= '0;
      S <= '0;
      cout <= 1'b0;
      ovf <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && in_valid) begin
        a_r <= a;
        b_r <= b ^ {WIDTH{sub}};
        carry <= ci ^ sub;
        cnt <= '0;
        acc <= '0;
      end else if (state == RUN) begin
        acc <= acc_nx;
        carry <= c[DIGIT];
        cnt <= last ? '0 : cnt + 1'b1;
        if (last) begin
          S <= acc_nx;
          cout <= c[DIGIT];
          ovf <= c[DIGIT] ^ c[DIGIT-1];
        end
      end
    end
  end
endmodule

// File: tb/tb_digit_serial_adder.sv
// tb_digit_serial_adder: four lanes (DIGIT = 1, 2, 4, 8) share stimulus; a per-lane queue holds expected results
module tb_digit_serial_adder;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, ci = 1'b0, sub = 1'b0, out_ready = 1'b1;
  logic [7:0] a = '0, b = '0;
  logic in_ready_o [4], out_valid_o [4], cout_o [4], ovf_o [4], busy_o [4];
  logic [7:0] s_o [4];
  logic [9:0] exp_q [4][$];
  logic [9:0] got [4];
  int lat [4];
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  for (genvar k = 0; k < 4; k++) begin : g_lane
    digit_serial_adder #(.WIDTH(8), .DIGIT(1 << k)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_o[k]),
      .a(a), .b(b), .ci(ci), .sub(sub),
      .out_valid(out_valid_o[k]), .out_ready(out_ready),
      .S(s_o[k]), .cout(cout_o[k]), .ovf(ovf_o[k]), .busy(busy_o[k])
    );
  end
  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic c, input logic s);
    logic [7:0] yy;
    logic [8:0] t;
    yy = s ? ~y : y;
    t = {1'b0, x} + {1'b0, yy} + {8'd0, s ? ~c : c};
    return {t[8], (x[7] == yy[7]) && (t[7] != x[7]), t[7:0]};
  endfunction
  task automatic issue(input logic [7:0] x, input logic [7:0] y, input logic c, input logic s, input logic [9:0] e);
    a = x; b = y; ci = c; sub = s; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) exp_q[k].push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  task automatic collect;
    for (int k = 0; k < 4; k++) begin
      got[k] = 'x;
      lat[k] = -1;
    end
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++)
        if (out_valid_o[k] && lat[k] < 0) begin
          got[k] = {cout_o[k], ovf_o[k], s_o[k]};
          lat[k] = j;
        end
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({in_ready_o[k], out_valid_o[k], busy_o[k], cout_o[k], ovf_o[k], s_o[k]} !== 13'b1_0000_0000_0000) begin
        failures++;
        $display("FAIL reset lane%0d rdy=%b vld=%b busy=%b cout=%b ovf=%b S=%h exp rdy=1 rest 0",
                 k, in_ready_o[k], out_valid_o[k], busy_o[k], cout_o[k], ovf_o[k], s_o[k]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_add;
    logic [7:0] ta [3] = '{8'h7F, 8'hFF, 8'h80};
    logic [7:0] tb [3] = '{8'h01, 8'h01, 8'h80};
    logic tc [3] = '{1'b0, 1'b1, 1'b0};
    logic [9:0] te [3] = '{10'h180, 10'h201, 10'h300};
    logic [9:0] e;
    for (int t = 0; t < 3; t++) begin
      issue(ta[t], tb[t], tc[t], 1'b0, te[t]);
      collect();
      for (int k = 0; k < 4; k++) begin
        e = exp_q[k].pop_front();
        checks += 2;
        if (got[k] !== e) begin
          failures++;
          $display("FAIL add%0d lane%0d {cout,ovf,S} got=%h exp=%h", t, k, got[k], e);
        end
        if (lat[k] != (8 >> k)) begin
          failures++;
          $display("FAIL add%0d lane%0d latency got=%0d exp=%0d", t, k, lat[k], 8 >> k);
        end
      end
    end
  endtask
  task automatic test_sub;
    logic [7:0] ta [2] = '{8'h05, 8'h07};
    logic [7:0] tb [2] = '{8'h07, 8'h05};
    logic tc [2] = '{1'b0, 1'b1};
    logic [9:0] te [2] = '{10'h0FE, 10'h201};
    logic [9:0] e;
    for (int t = 0; t < 2; t++) begin
      issue(ta[t], tb[t], tc[t], 1'b1, te[t]);
      collect();
      for (int k = 0; k < 4; k++) begin
        e = exp_q[k].pop_front();
        checks++;
        if (got[k] !== e) begin
          failures++;
          $display("FAIL sub%0d lane%0d {cout,ovf,S} got=%h exp=%h", t, k, got[k], e);
        end
      end
    end
  endtask
  task automatic test_digit4;
    logic [9:0] e;
    issue(8'h3C, 8'h5A, 1'b0, 1'b0, 10'h196);
    collect();
    for (int k = 0; k < 4; k++) begin
      e = exp_q[k].pop_front();
      checks += 2;
      if (got[k] !== e) begin
        failures++;
        $display("FAIL digit4 lane%0d {cout,ovf,S} got=%h exp=%h", k, got[k], e);
      end
      if (lat[k] != (8 >> k)) begin
        failures++;
        $display("FAIL digit4 lane%0d latency got=%0d exp=%0d", k, lat[k], 8 >> k);
      end
    end
  endtask
  task automatic test_random;
    logic [7:0] x, y;
    logic c, s;
    logic [9:0] e;
    for (int n = 0; n < 1000; n++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      c = 1'($urandom);
      s = 1'($urandom);
      issue(x, y, c, s, model(x, y, c, s));
      collect();
      for (int k = 0; k < 4; k++) begin
        e = exp_q[k].pop_front();
        checks++;
        if (got[k] !== e || lat[k] != (8 >> k)) begin
          failures++;
          $display("FAIL random%0d lane%0d a=%h b=%h ci=%b sub=%b got=%h lat=%0d exp=%h lat=%0d",
                   n, k, x, y, c, s, got[k], lat[k], e, 8 >> k);
        end
      end
    end
  endtask
  task automatic test_back_to_back;
    logic [9:0] e;
    out_ready = 1'b0;
    issue(8'hC8, 8'h32, 1'b0, 1'b1, 10'h296);
    repeat (8) @(negedge clk);
    a = 8'h12; b = 8'h34; ci = 1'b0; sub = 1'b0; in_valid = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        checks++;
        if ({out_valid_o[k], in_ready_o[k], busy_o[k], cout_o[k], ovf_o[k], s_o[k]} !== {3'b101, exp_q[k][0]}) begin
          failures++;
          $display("FAIL hold%0d lane%0d vld=%b rdy=%b busy=%b res=%h exp vld=1 rdy=0 busy=1 res=%h",
                   j, k, out_valid_o[k], in_ready_o[k], busy_o[k], {cout_o[k], ovf_o[k], s_o[k]}, exp_q[k][0]);
        end
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      void'(exp_q[k].pop_front());
      exp_q[k].push_back(10'h046);
      checks++;
      if ({in_ready_o[k], out_valid_o[k], busy_o[k]} !== 3'b100) begin
        failures++;
        $display("FAIL handshake lane%0d rdy=%b vld=%b busy=%b exp rdy=1 vld=0 busy=0",
                 k, in_ready_o[k], out_valid_o[k], busy_o[k]);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (busy_o[k] !== 1'b1) begin
        failures++;
        $display("FAIL accept_after_idle lane%0d busy=%b exp=1", k, busy_o[k]);
      end
    end
    collect();
    for (int k = 0; k < 4; k++) begin
      e = exp_q[k].pop_front();
      checks++;
      if (got[k] !== e || lat[k] != (8 >> k)) begin
        failures++;
        $display("FAIL next_op lane%0d got=%h lat=%0d exp=%h lat=%0d", k, got[k], lat[k], e, 8 >> k);
      end
    end
  endtask
  task automatic test_abort;
    logic seen;
    logic [9:0] e;
    out_ready = 1'b0;
    issue(8'h11, 8'h22, 1'b0, 1'b0, 10'h033);
    for (int j = 1; j <= 2; j++) begin
      @(negedge clk);
      checks++;
      if ({out_valid_o[0], busy_o[0]} !== 2'b01) begin
        failures++;
        $display("FAIL abort_run%0d lane0 vld=%b busy=%b exp vld=0 busy=1", j, out_valid_o[0], busy_o[0]);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_q[k].delete();
      checks++;
      if ({in_ready_o[k], out_valid_o[k], busy_o[k], s_o[k]} !== 11'b100_0000_0000) begin
        failures++;
        $display("FAIL abort_reset lane%0d rdy=%b vld=%b busy=%b S=%h exp rdy=1 vld=0 busy=0 S=00",
                 k, in_ready_o[k], out_valid_o[k], busy_o[k], s_o[k]);
      end
    end
    out_ready = 1'b1;
    seen = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      seen |= out_valid_o[0];
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL aborted_output lane0 out_valid seen=%b exp=0", seen);
    end
    issue(8'h40, 8'h40, 1'b0, 1'b0, 10'h180);
    collect();
    for (int k = 0; k < 4; k++) begin
      e = exp_q[k].pop_front();
      checks++;
      if (got[k] !== e || lat[k] != (8 >> k)) begin
        failures++;
        $display("FAIL after_abort lane%0d got=%h lat=%0d exp=%h lat=%0d", k, got[k], lat[k], e, 8 >> k);
      end
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    @(negedge clk);
    test_reset();
    test_add();
    test_sub();
    test_digit4();
    test_back_to_back();
    test_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
